// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one shared full-adder cell (two half adders) plus carry FF.
// Latency: start accepted at edge N, done/sum/cout valid in the cycle after edge N+WIDTH.
// Backpressure: none; start is sampled only in IDLE, requests during RUN/DONE are dropped.
// Optional subtract mode is compiled in with macro SERIAL_ADD_SUB_EN (adds port i_sub).
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_opa_sh;
   logic [WIDTH-1:0]   r_opb_sh;
   // Holds the WIDTH-1 result bits collected so far; the final bit joins them on the last edge.
   logic [WIDTH-2:0]   r_res_sh;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_s1;
   logic               w_c1;
   logic               w_s;
   logic               w_c2;
   logic               w_carry_nxt;
   logic [WIDTH-1:0]   w_res_nxt;
   logic [WIDTH-1:0]   w_opb_load;
   logic               w_carry_load;

   // Shared full adder: two cascaded half adders on the current LSBs and the carry FF.
   assign w_s1        = r_opa_sh[0] ^ r_opb_sh[0];
   assign w_c1        = r_opa_sh[0] & r_opb_sh[0];
   assign w_s         = w_s1 ^ r_carry;
   assign w_c2        = w_s1 & r_carry;
   assign w_carry_nxt = w_c1 | w_c2;
   assign w_res_nxt   = {w_s, r_res_sh};

`ifdef SERIAL_ADD_SUB_EN
   // Subtract is a + ~b + 1: invert B and seed the carry with 1.
   assign w_opb_load   = i_sub ? ~i_b : i_b;
   assign w_carry_load = i_sub;
`else
   assign w_opb_load   = i_b;
   assign w_carry_load = 1'b0;
`endif

   // Sequencer FSM with datapath shift registers and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_opa_sh <= '0;
         r_opb_sh <= '0;
         r_res_sh <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_opa_sh <= i_a;
                  r_opb_sh <= w_opb_load;
                  r_carry  <= w_carry_load;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_carry  <= w_carry_nxt;
               r_res_sh <= w_res_nxt[WIDTH-1:1];
               r_opa_sh <= r_opa_sh >> 1;
               r_opb_sh <= r_opb_sh >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_BIT) begin
                  // Result registers load on this edge so they are valid alongside done.
                  r_sum   <= w_res_nxt;
                  r_cout  <= w_carry_nxt;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: vector table plus hand-written sequences
// for dropped start, back-to-back operation, and asynchronous reset in the middle of RUN.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] prev_sum;
   logic             prev_cout;

   typedef struct {
      logic [WIDTH-1:0] va;
      logic [WIDTH-1:0] vb;
      logic [WIDTH-1:0] es;
      logic             ec;
   } vec_t;

   vec_t tbl [8];

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_a     (a),
      .i_b     (b),
`ifdef SERIAL_ADD_SUB_EN
      .i_sub   (sub),
`endif
      .o_busy  (busy),
      .o_done  (done),
      .o_sum   (sum),
      .o_cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full operation: accept, watch busy and latency, compare the result, check done is a pulse.
   task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vs, input logic [WIDTH-1:0] es, input logic ec);
      int busy_cnt;
      int lat;
      bit got;
      bit held_bad;
      @(negedge clk);
      a = va;
      b = vb;
`ifdef SERIAL_ADD_SUB_EN
      sub = vs;
`else
      if (vs) $display("note: %s requests subtract in an add-only build", name);
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~va;
      b = ~vb;
      busy_cnt = busy ? 1 : 0;
      lat = 0;
      got = 0;
      held_bad = (sum !== prev_sum) || (cout !== prev_cout);
      for (int k = 1; k <= 20 && !got; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1;
            lat = k;
         end else begin
            if (busy) busy_cnt++;
            if ((sum !== prev_sum) || (cout !== prev_cout)) held_bad = 1;
         end
      end
      chk({name, "_latency"}, lat, WIDTH);
      chk({name, "_busy_cycles"}, busy_cnt, WIDTH);
      chk({name, "_sum_held_in_run"}, {31'd0, held_bad}, 0);
      chk({name, "_sum"}, sum, es);
      chk({name, "_cout"}, cout, ec);
      @(posedge clk);
      #1;
      chk({name, "_done_one_cycle"}, {31'd0, done}, 0);
      prev_sum = es;
      prev_cout = ec;
   endtask

   initial begin
      int ndone;
      int t_last;
      int t_now;
      logic [WIDTH-1:0] ha [3];
      logic [WIDTH-1:0] hb [3];
      logic [WIDTH-1:0] hs [3];
      logic             hc [3];

      tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      tbl[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
      tbl[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
      tbl[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
      tbl[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
      tbl[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
      tbl[7] = '{8'h0F, 8'h01, 8'h10, 1'b0};

      ha[0] = 8'h11; hb[0] = 8'h22; hs[0] = 8'h33; hc[0] = 1'b0;
      ha[1] = 8'h55; hb[1] = 8'h55; hs[1] = 8'hAA; hc[1] = 1'b0;
      ha[2] = 8'hF0; hb[2] = 8'h20; hs[2] = 8'h10; hc[2] = 1'b1;

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      prev_sum = '0;
      prev_cout = 1'b0;

      // Reset state
      #12;
      chk("reset_busy", {31'd0, busy}, 0);
      chk("reset_done", {31'd0, done}, 0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", {31'd0, cout}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven additions
      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].va, tbl[i].vb, 1'b0, tbl[i].es, tbl[i].ec);
      end

      // Start pulsed during RUN is dropped
      @(negedge clk);
      a = 8'h12;
      b = 8'h34;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a = 8'hFF;
      b = 8'hFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("drop_done_count", ndone, 1);
      chk("drop_sum", sum, 8'h46);
      chk("drop_cout", {31'd0, cout}, 0);
      chk("drop_idle_busy", {31'd0, busy}, 0);
      prev_sum = 8'h46;
      prev_cout = 1'b0;

      // Start held high: one result every WIDTH+2 cycles
      @(negedge clk);
      a = ha[0];
      b = hb[0];
      start = 1'b1;
      t_last = 0;
      t_now = 0;
      for (int i = 0; i < 3; i++) begin
         bit got;
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            t_now++;
            if (done) got = 1;
         end
         chk($sformatf("held%0d_seen", i), {31'd0, got}, 1);
         chk($sformatf("held%0d_sum", i), sum, hs[i]);
         chk($sformatf("held%0d_cout", i), {31'd0, cout}, {31'd0, hc[i]});
         if (i > 0) chk($sformatf("held%0d_spacing", i), t_now - t_last, WIDTH + 2);
         t_last = t_now;
         if (i < 2) begin
            a = ha[i+1];
            b = hb[i+1];
         end else begin
            start = 1'b0;
         end
      end
      prev_sum = hs[2];
      prev_cout = hc[2];
      repeat (3) @(posedge clk);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      a = 8'h33;
      b = 8'h44;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_done", {31'd0, done}, 0);
      chk("arst_sum", sum, 0);
      chk("arst_cout", {31'd0, cout}, 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("arst_no_done", ndone, 0);
      @(negedge clk);
      rst = 1'b0;
      prev_sum = '0;
      prev_cout = 1'b0;
      run_op("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      run_op("sub_5m7", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
      run_op("sub_7m5", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
      run_op("sub_off", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
